// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian button synchroniser, debouncer and request latch
module ped_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int BLINK_W         = 24
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic key_n,
  input  logic ped_ack,
  output logic btn_level,
  output logic btn_pulse,
  output logic ped_req,
  output logic wait_led
);

  localparam logic [CNT_W-1:0]   DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVED  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               s1;
  logic               s2;
  logic               mismatch;
  logic [CNT_W-1:0]   deb_cnt;
  logic [BLINK_W-1:0] blink_cnt;

  // Synchroniser idles at 1 (released) so reset never looks like a press
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  assign mismatch = (~s2 != btn_level);

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else if (mismatch && deb_cnt == DEB_LAST) begin
      deb_cnt   <= '0;
      btn_level <= ~btn_level;
      btn_pulse <= ~btn_level;
    end else begin
      deb_cnt   <= mismatch ? deb_cnt + 1'b1 : '0;
      btn_pulse <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Ack outranks a simultaneous press in PENDING; no press queueing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (btn_pulse) state_nxt = PENDING;
      PENDING: if (ped_ack) state_nxt = SERVED;
      SERVED:  if (!btn_level && !ped_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ped_req = (state == PENDING);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      wait_led  <= 1'b0;
      blink_cnt <= '0;
    end else if (state_nxt == PENDING && state != PENDING) begin
      wait_led  <= 1'b1;
      blink_cnt <= '0;
    end else if (state_nxt == PENDING) begin
      if (blink_cnt == BLINK_LAST) begin
        wait_led  <= ~wait_led;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      wait_led  <= 1'b0;
      blink_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb/tb_ped_request_ctrl.sv - directed and randomized bench for ped_request_ctrl
module tb_ped_request_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 3;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  logic key_n    = 1'b1;
  logic ped_ack  = 1'b0;
  logic btn_level;
  logic btn_pulse;
  logic ped_req;
  logic wait_led;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // Reference state: raw key history, accepted level, press request bookkeeping
  bit m_k1, m_k2;
  bit m_lvl, m_pulse, m_req, m_served;
  int m_run, m_age;

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(4),
    .BLINK_CYCLES(BLK),
    .BLINK_W(3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .ped_ack  (ped_ack),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .ped_req  (ped_req),
    .wait_led (wait_led)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit pressed, p_old, l_old;
    if (!rst_n) begin
      m_k1 = 1'b1; m_k2 = 1'b1;
      m_lvl = 1'b0; m_pulse = 1'b0; m_req = 1'b0; m_served = 1'b0;
      m_run = 0; m_age = 0;
      return;
    end
    p_old   = m_pulse;
    l_old   = m_lvl;
    pressed = !m_k2;
    m_k2    = m_k1;
    m_k1    = key_n;
    m_pulse = 1'b0;
    if (pressed != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl   = pressed;
        m_run   = 0;
        m_pulse = pressed;
      end
    end else begin
      m_run = 0;
    end
    if (m_req) begin
      if (ped_ack) begin
        m_req    = 1'b0;
        m_served = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_served) begin
      if (!l_old && !ped_ack) m_served = 1'b0;
    end else if (p_old) begin
      m_req = 1'b1;
      m_age = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check("model_btn_level", btn_level, m_lvl);
    check("model_btn_pulse", btn_pulse, m_pulse);
    check("model_ped_req", ped_req, m_req);
    check("model_wait_led", wait_led, m_req && ((m_age / BLK) % 2 == 0));
    if (btn_pulse === 1'b1) pulses++;
  endtask

  task automatic hold(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic edges_until_pulse(output int n);
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      tick();
      if (btn_pulse === 1'b1) n = i;
    end
  endtask

  initial begin
    int n;
    int run;
    logic [6:0] led_seq;
    logic [6:0] led_exp;

    rst_n = 1'b0;
    key_n = 1'b0;
    hold(2);
    check("reset_level", btn_level, 0);
    check("reset_pulse", btn_pulse, 0);
    check("reset_req", ped_req, 0);
    check("reset_led", wait_led, 0);
    rst_n = 1'b1;
    edges_until_pulse(n);
    check("reset_release_pulse_edge", n, 6);
    tick();
    check("reset_release_req", ped_req, 1);

    ped_ack = 1'b1;
    tick();
    ped_ack = 1'b0;
    check("ack_clears_req", ped_req, 0);
    pulses = 0;
    hold(10);
    check("held_key_no_pulse", pulses, 0);
    check("held_key_no_req", ped_req, 0);

    key_n = 1'b1;
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      tick();
      if (btn_level === 1'b0) n = i;
    end
    check("release_level_edge", n, 6);
    hold(2);

    pulses = 0;
    key_n = 1'b0;
    edges_until_pulse(n);
    check("press_pulse_edge", n, 6);
    led_seq = '0;
    tick();
    check("press_req", ped_req, 1);
    led_seq[6] = wait_led;
    for (int i = 5; i >= 0; i--) begin
      tick();
      led_seq[i] = wait_led;
    end
    led_exp = 7'b1110001;
    check("blink_pattern", led_seq, led_exp);
    check("press_single_pulse", pulses, 1);

    key_n = 1'b1;
    hold(8);
    check("pending_through_release", ped_req, 1);
    key_n = 1'b0;
    edges_until_pulse(n);
    check("second_press_pulse_edge", n, 6);
    ped_ack = 1'b1;
    tick();
    ped_ack = 1'b0;
    check("pulse_ack_together_req", ped_req, 0);
    check("pulse_ack_together_led", wait_led, 0);
    hold(6);
    check("served_stays_idle_req", ped_req, 0);

    key_n = 1'b1;
    hold(10);
    pulses = 0;
    key_n = 1'b0; hold(3);
    key_n = 1'b1; hold(1);
    key_n = 1'b0; hold(3);
    key_n = 1'b1; hold(8);
    check("bounce_no_pulse", pulses, 0);
    check("bounce_no_req", ped_req, 0);
    key_n = 1'b0;
    hold(10);
    check("after_bounce_one_pulse", pulses, 1);
    check("after_bounce_req", ped_req, 1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_reset_req", ped_req, 0);
    check("mid_reset_led", wait_led, 0);
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      tick();
      if (ped_req === 1'b1) n = i;
    end
    check("mid_reset_rerequest_edge", n, 7);

    run = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run == 0) begin
        key_n = 1'($urandom_range(0, 1));
        run   = $urandom_range(1, 9);
      end
      run--;
      ped_ack = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
